// File: rtl/count_load_ctrl.sv
// count_load_ctrl: upstream controller for a loadable incrementing counter.
// Accepts {start, end, periodic} commands on a valid/ready port, loads the
// counter, enables it until its output equals the end value, then pulses done
// and either returns to idle or reloads for another period.
module count_load_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic             cmd_periodic,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic [WIDTH-1:0] cnt_data,
  output logic             cnt_load,
  output logic             cnt_enable,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_end;
  logic             r_per;
  logic             w_accept;
  logic             w_at_end;

  // Only equality is detected; a count that jumps past r_end keeps running.
  assign w_at_end = (cnt_q == r_end);
  assign w_accept = cmd_valid & cmd_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Command capture; only updated on a handshake, so cmd_* may change freely while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start <= '0;
      r_end   <= '0;
      r_per   <= 1'b0;
    end else if (w_accept) begin
      r_start <= cmd_start;
      r_end   <= cmd_end;
      r_per   <= cmd_periodic;
    end
  end

  // Next-state and outputs; every output is forced low while reset is high.
  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    cnt_data   = '0;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      cnt_data   = r_start;
      cmd_ready  = (r_state == S_IDLE) & ~abort;
      cnt_load   = (r_state == S_LOAD) & ~abort;
      cnt_enable = (r_state == S_RUN) & ~w_at_end & ~abort;
      done       = (r_state == S_DONE);
      busy       = (r_state != S_IDLE);
    end
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_LOAD;
      // Counter shows r_start from the first RUN cycle.
      S_LOAD: w_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)         w_next = S_IDLE;
        else if (w_at_end) w_next = S_DONE;
      end
      // abort here still lets done show this cycle but blocks the reload.
      S_DONE: w_next = (r_per & ~abort) ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_count_load_ctrl.sv
// Bench for count_load_ctrl: directed commands push expected done events
// (cycle, enable count, load data, reload) into a queue; a monitor on the
// falling edge pops and compares whenever done is seen.
module tb_count_load_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_periodic, abort;
  logic [7:0] cmd_start, cmd_end, cnt_q, cnt_data;
  logic       cnt_load, cnt_enable, done, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    int         nen;
    logic [7:0] start;
    bit         reload;
  } exp_t;
  exp_t q[$];

  count_load_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_periodic(cmd_periodic),
    .abort(abort), .cnt_q(cnt_q), .cnt_data(cnt_data), .cnt_load(cnt_load),
    .cnt_enable(cnt_enable), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter stage the controller drives.
  always @(posedge clk) begin
    if (reset)           cnt_q <= 8'h00;
    else if (cnt_load)   cnt_q <= cnt_data;
    else if (cnt_enable) cnt_q <= cnt_q + 8'h01;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard.
  int n_en = 0;
  bit reload_chk = 0;
  bit reload_exp = 0;
  always @(negedge clk) begin
    if (reset) begin
      n_en = 0;
      reload_chk = 0;
    end else begin
      if (reload_chk) check("reload_after_done", int'(cnt_load), int'(reload_exp));
      reload_chk = 0;
      if (cnt_load)   n_en = 0;
      if (cnt_enable) n_en++;
      if (busy && q.size() > 0) check("cnt_data_hold", int'(cnt_data), int'(q[0].start));
      if (done) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("enable_count", n_en, e.nen);
          reload_chk = 1;
          reload_exp = e.reload;
        end
      end
    end
  end

  // Hold cmd_valid until accepted; push nper expected done events.
  task automatic issue(input logic [7:0] s, input logic [7:0] e, input bit p,
                       input int nper, output int acc);
    logic [7:0] d;
    exp_t x;
    d = e - s;
    acc = -1;
    @(posedge clk); #1;
    cmd_start = s; cmd_end = e; cmd_periodic = p; cmd_valid = 1'b1;
    for (int i = 0; i < 300 && acc < 0; i++) begin
      #2;
      if (cmd_ready) begin
        acc = cyc;
        for (int k = 0; k < nper; k++) begin
          x.cyc = acc + (k + 1) * (int'(d) + 3);
          x.nen = int'(d);
          x.start = s;
          x.reload = (k < nper - 1);
          q.push_back(x);
        end
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (acc < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 1000 && cyc < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int a, b;
  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_start = 8'h00; cmd_end = 8'h00;
    cmd_periodic = 1'b0; abort = 1'b0;
    // 1: reset
    repeat (2) begin
      @(negedge clk);
      check("rst_outputs", int'({cmd_ready, cnt_load, cnt_enable, done, busy}), 0);
      check("rst_data", int'(cnt_data), 0);
    end
    @(posedge clk); #1 reset = 1'b0;
    #3;
    check("post_rst_ready", int'(cmd_ready), 1);
    check("post_rst_others", int'({cnt_load, cnt_enable, done, busy}), 0);

    // 2: 03 -> 05 non-periodic, load data and idle afterwards
    issue(8'h03, 8'h05, 1'b0, 1, a);
    #2 check("load_strobe", int'(cnt_load), 1);
    check("load_data", int'(cnt_data), 8'h03);
    wait_cyc(a + 6); #2;
    check("idle_ready", int'(cmd_ready), 1);
    check("idle_busy", int'(busy), 0);

    // 3: wrap and zero-length
    issue(8'hFE, 8'h01, 1'b0, 1, a);
    issue(8'h07, 8'h07, 1'b0, 1, a);

    // 4 + 5b: periodic 00 -> 03, abort during fourth done
    issue(8'h00, 8'h03, 1'b1, 4, a);
    wait_cyc(a + 24);
    abort = 1'b1;
    #2 check("done_under_abort", int'(done), 1);
    @(posedge clk); #1 abort = 1'b0;
    #2 check("no_reload_busy", int'(busy), 0);

    // 5a: abort mid-RUN at count 02
    issue(8'h00, 8'h05, 1'b0, 0, a);
    wait_cyc(a + 4);
    abort = 1'b1;
    #2 check("abort_cnt_q", int'(cnt_q), 2);
    check("abort_enable", int'(cnt_enable), 0);
    check("abort_ready", int'(cmd_ready), 0);
    @(posedge clk); #1 abort = 1'b0;
    #2 check("abort_idle", int'(busy), 0);

    // 6a: valid held while busy, next start differs from current
    issue(8'h01, 8'h04, 1'b0, 1, a);
    issue(8'h20, 8'h22, 1'b0, 1, b);
    check("held_accept_cycle", b, a + 7);

    // 6b: reset during RUN
    issue(8'h10, 8'h20, 1'b0, 0, a);
    wait_cyc(a + 5);
    reset = 1'b1;
    #2 check("rst_run_outputs", int'({cmd_ready, cnt_load, cnt_enable, done, busy}), 0);
    @(posedge clk); #1 reset = 1'b0;
    #2 check("rst_run_idle", int'({busy, cmd_ready}), 1);

    repeat (25) @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
